orientation_capture: RTL and testbench
======================================

Name: orientation_capture

Overview:
Sequencer directly upstream of orientation_math. It captures a filtered "original" location from the ultrasound locator, then commands the robot to drive one step forward and waits for the move to finish and settle. It then captures a filtered "final" location and presents both 12-bit r_theta words to orientation_math with a done strobe. Every wait has a timeout so the system never hangs.

Parameters:
MEAS_TIMEOUT, 65_000_000, max cycles allowed per measurement phase (1 s at 65 MHz)
MOVE_TIMEOUT, 195_000_000, max cycles from move_cmd to move_done
SETTLE_CYCLES, 6_500_000, idle cycles after move_done before final measurement
R_TOL, 4, max |r1-r2| for two samples to count as agreeing
CNT_W, 28, width of the shared cycle counter; must hold the largest timeout

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a capture sequence
loc_valid  in  1  one-cycle strobe: loc_r_theta holds a new locator sample
loc_r_theta  in  12  sample; r=[7:0] unsigned, theta=[11:8] sector code 1..6 (15+30n deg)
move_done  in  1  one-cycle ack from robot transmitter that the forward step finished
move_cmd  out  1  one-cycle pulse: command robot one step forward
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse: both output words valid
error  out  1  level; set on timeout, cleared by next accepted start
error_code  out  2  01 orig-meas timeout, 10 move timeout, 11 final-meas timeout, 00 none
r_theta_original  out  12  filtered original location, same packing as loc_r_theta
r_theta_final  out  12  filtered final location

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0, counter 0, filter cleared.
- States: IDLE, MEAS_ORIG, MOVE, SETTLE, MEAS_FINAL.
- IDLE: start=1 -> MEAS_ORIG next cycle. Same edge: busy=1, error=0, error_code=00, counter=0, filter cleared.
- start while busy is ignored. move_done outside MOVE is ignored. loc_valid outside MEAS_* is ignored.
- Pair filter (MEAS_*):
  - Sample with theta 0 or >6: discarded and pending sample cleared.
  - No pending sample: a valid sample becomes pending.
  - Pending sample exists: new sample agrees if theta is equal and |r_new - r_pend| <= R_TOL.
    - Agree: result r = (r_pend + r_new) >> 1, computed in 9 bits and truncated; theta = common theta.
    - Disagree: new sample replaces pending.
- MEAS_ORIG: on an agreeing loc_valid at cycle T:
  - r_theta_original updated at T+1.
  - State MOVE at T+1, move_cmd=1 for cycle T+1 only, counter reset.
- MOVE: on move_done -> SETTLE, counter reset.
  - If counter reaches MOVE_TIMEOUT-1 without move_done -> error path, code 10.
  - move_done in the same cycle as timeout expiry: move_done wins.
- SETTLE: counts SETTLE_CYCLES, then -> MEAS_FINAL with counter and filter cleared.
- MEAS_FINAL: on an agreeing sample at cycle T:
  - r_theta_final updated at T+1.
  - done=1 for cycle T+1 only, busy=0 at T+1, state IDLE.
- Timeouts in MEAS_* when counter reaches MEAS_TIMEOUT-1; an agreeing sample in the expiry cycle wins.
- Error path: error=1, error_code set, busy=0, state IDLE, done not pulsed.
  - r_theta_final is not updated on error.
  - r_theta_original keeps whatever was captured.
- r_theta_* hold their values until overwritten by a later capture. They are meaningful only when qualified by done.
- Counter is a saturating up-counter of CNT_W bits, reset on every state entry.
- Reset mid-sequence aborts immediately: no move_cmd, done, or error is emitted.

Decomposition:
- Package orientation_pkg:
  - state encoding
  - theta sector constants THETA_15..THETA_165 = 1..6
  - error-code constants
  - field slices R_MSB=7, THETA_LSB=8
- Sub-module loc_pair_filter, instantiated once and shared by both measurement phases.
  - Inputs: clock, reset_n, clear, sample_valid, sample.
  - Outputs: result_valid, result (registered, one-cycle latency).

Test Plan:
1. start; loc samples (theta2,r100), (theta2,r102); move_done after 20 cycles; after SETTLE, samples (theta3,r80), (theta3,r84) -> move_cmd pulses once; r_theta_original=0x265, r_theta_final=0x352; done one cycle after last sample; busy low.
2. MEAS_ORIG samples (theta1,r50), (theta1,r60), (theta1,r61) -> first pair rejected (|diff|=10); original=0x13C from 60/61.
3. Samples with theta=0 and theta=7 interleaved between (theta5,r30) and (theta5,r30) -> invalid samples clear pending; no capture until two consecutive valid agreeing samples.
4. MOVE_TIMEOUT=50, no move_done -> error=1, code 10 at cycle 50 after move_cmd; done never pulses; next start clears error.
5. move_done exactly on timeout cycle -> SETTLE entered, no error. start pulsed while busy -> ignored.
6. reset_n low during SETTLE -> outputs 0 asynchronously; after release, state IDLE, no spurious move_cmd or done.

Source files
------------

// File: rtl/orientation_pkg.sv
// Purpose: shared types and constants for the orientation capture sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package orientation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEAS_ORIG,
    ST_MOVE,
    ST_SETTLE,
    ST_MEAS_FINAL
  } state_t;

  // Sector codes: theta = 15 + 30*(code-1) degrees
  localparam logic [3:0] THETA_15  = 4'd1;
  localparam logic [3:0] THETA_45  = 4'd2;
  localparam logic [3:0] THETA_75  = 4'd3;
  localparam logic [3:0] THETA_105 = 4'd4;
  localparam logic [3:0] THETA_135 = 4'd5;
  localparam logic [3:0] THETA_165 = 4'd6;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_ORIG_MEAS  = 2'b01;
  localparam logic [1:0] ERR_MOVE       = 2'b10;
  localparam logic [1:0] ERR_FINAL_MEAS = 2'b11;

  // Packing of a 12-bit r_theta word
  localparam int R_MSB     = 7;
  localparam int THETA_LSB = 8;

  typedef struct packed {
    logic [3:0] theta;
    logic [7:0] r;
  } loc_t;

  function automatic logic theta_valid(input logic [3:0] theta);
    case (theta)
      THETA_15, THETA_45, THETA_75, THETA_105, THETA_135, THETA_165: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/loc_pair_filter.sv
// Purpose: accepts a location only when two consecutive valid samples agree; outputs their mean.
// Latency: hit is combinational in the agreeing-sample cycle; result/result_valid one cycle later.
// Backpressure: none; every sample_valid is consumed in its cycle.
// Ports: clock, reset_n; clear drops the pending sample; sample_valid/sample in;
//        hit (agreement this cycle), result_valid/result (registered filtered word).
module loc_pair_filter
  import orientation_pkg::*;
#(
  parameter int R_TOL = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  output logic        hit,
  output logic        result_valid,
  output logic [11:0] result
);

  loc_t       smp;
  loc_t       pend;
  logic       pend_vld;
  logic       smp_ok;
  logic [7:0] r_diff;
  logic [7:0] r_avg;

  always_comb begin
    smp    = '{theta: sample[11:THETA_LSB], r: sample[R_MSB:0]};
    smp_ok = theta_valid(smp.theta);
    r_diff = (smp.r >= pend.r) ? (smp.r - pend.r) : (pend.r - smp.r);
    // 9-bit sum so the carry survives before halving
    r_avg  = 8'(({1'b0, smp.r} + {1'b0, pend.r}) >> 1);
    hit    = sample_valid && !clear && smp_ok && pend_vld &&
             (smp.theta == pend.theta) && (r_diff <= 8'(R_TOL));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld     <= 1'b0;
      pend         <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else if (clear) begin
      pend_vld     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= hit;
      if (sample_valid) begin
        if (!smp_ok) begin
          // A corrupt sample breaks the consecutive-pair requirement
          pend_vld <= 1'b0;
        end else if (hit) begin
          pend_vld <= 1'b0;
          result   <= {pend.theta, r_avg};
        end else begin
          pend_vld <= 1'b1;
          pend     <= smp;
        end
      end
    end
  end

endmodule

// File: rtl/orientation_capture.sv
// Purpose: measure original location, step robot forward, settle, measure final location.
// Latency: move_cmd/done/r_theta_* appear one cycle after the agreeing locator sample.
// Backpressure: none; start while busy and out-of-phase strobes are dropped, every wait times out.
// Ports: clock, reset_n, start, loc_valid/loc_r_theta (locator), move_done (robot ack) in;
//        move_cmd, busy, done, error, error_code, r_theta_original, r_theta_final out.
module orientation_capture
  import orientation_pkg::*;
#(
  parameter int MEAS_TIMEOUT  = 65_000_000,
  parameter int MOVE_TIMEOUT  = 195_000_000,
  parameter int SETTLE_CYCLES = 6_500_000,
  parameter int R_TOL         = 4,
  parameter int CNT_W         = 28
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        loc_valid,
  input  logic [11:0] loc_r_theta,
  input  logic        move_done,
  output logic        move_cmd,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [11:0] r_theta_original,
  output logic [11:0] r_theta_final
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [11:0]        orig_q;
  logic [11:0]        fin_q;

  logic               filt_clear;
  logic               filt_sample_vld;
  logic               filt_hit;
  logic               filt_vld;
  logic [11:0]        filt_result;

  logic               meas_expired;
  logic               move_expired;
  logic               settle_end;
  logic               orig_live;
  logic               fin_live;

  always_comb begin
    cnt_inc         = (&cnt) ? cnt : cnt + CNT_W'(1);
    meas_expired    = cnt >= CNT_W'(MEAS_TIMEOUT - 1);
    move_expired    = cnt >= CNT_W'(MOVE_TIMEOUT - 1);
    settle_end      = (state == ST_SETTLE) && (cnt >= CNT_W'(SETTLE_CYCLES - 1));
    filt_clear      = ((state == ST_IDLE) && start) || settle_end;
    filt_sample_vld = loc_valid && ((state == ST_MEAS_ORIG) || (state == ST_MEAS_FINAL));
    // The filter's registered result is live in the cycle after a hit; the state we
    // landed in tells which phase produced it.
    orig_live       = filt_vld && (state == ST_MOVE);
    fin_live        = filt_vld && (state == ST_IDLE);
  end

  loc_pair_filter #(.R_TOL(R_TOL)) u_filter (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (filt_clear),
    .sample_valid (filt_sample_vld),
    .sample       (loc_r_theta),
    .hit          (filt_hit),
    .result_valid (filt_vld),
    .result       (filt_result)
  );

  // Outputs follow the filter register in the capture cycle, then the local hold copy
  assign r_theta_original = orig_live ? filt_result : orig_q;
  assign r_theta_final    = fin_live  ? filt_result : fin_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      move_cmd   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
      orig_q     <= '0;
      fin_q      <= '0;
    end else begin
      move_cmd <= 1'b0;
      done     <= 1'b0;
      if (orig_live) orig_q <= filt_result;
      if (fin_live)  fin_q  <= filt_result;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_MEAS_ORIG;
            busy       <= 1'b1;
            error      <= 1'b0;
            error_code <= ERR_NONE;
            cnt        <= '0;
          end
        end

        ST_MEAS_ORIG: begin
          if (filt_hit) begin
            state    <= ST_MOVE;
            move_cmd <= 1'b1;
            cnt      <= '0;
          end else if (meas_expired) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_ORIG_MEAS;
            cnt        <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_MOVE: begin
          // Ack beats timeout when both land in the same cycle
          if (move_done) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end else if (move_expired) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_MOVE;
            cnt        <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_SETTLE: begin
          if (settle_end) begin
            state <= ST_MEAS_FINAL;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_MEAS_FINAL: begin
          if (filt_hit) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (meas_expired) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_FINAL_MEAS;
            cnt        <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_capture.sv
module tb_orientation_capture;

  localparam int MEAS_TO = 200;
  localparam int MOVE_TO = 50;
  localparam int SETTLE  = 10;

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b1;
  logic        start       = 1'b0;
  logic        loc_valid   = 1'b0;
  logic [11:0] loc_r_theta = '0;
  logic        move_done   = 1'b0;
  logic        move_cmd;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;
  logic [11:0] r_theta_original;
  logic [11:0] r_theta_final;

  orientation_capture #(
    .MEAS_TIMEOUT  (MEAS_TO),
    .MOVE_TIMEOUT  (MOVE_TO),
    .SETTLE_CYCLES (SETTLE),
    .R_TOL         (4),
    .CNT_W         (28)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .loc_valid        (loc_valid),
    .loc_r_theta      (loc_r_theta),
    .move_done        (move_done),
    .move_cmd         (move_cmd),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .error_code       (error_code),
    .r_theta_original (r_theta_original),
    .r_theta_final    (r_theta_final)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_MOVE, EV_DONE, EV_ERR, EV_NONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [11:0] orig;
    logic [11:0] fin;
    logic [1:0]  code;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: r is the truncated mean of the two agreeing samples
  function automatic logic [11:0] pair(input int theta, input int r1, input int r2);
    int avg;
    avg = (r1 + r2) / 2;
    return 12'((theta << 8) | (avg & 8'hFF));
  endfunction

  task automatic push_ev(input ev_kind_t k, input logic [11:0] o, input logic [11:0] f,
                         input logic [1:0] c);
    ev_t e;
    e.kind = k; e.orig = o; e.fin = f; e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int theta, input int r);
    loc_r_theta = 12'((theta << 8) | r);
    loc_valid   = 1'b1;
    tick(1);
    loc_valid   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Scoreboard: every move_cmd, done or error rise must match the next expected event
  logic err_q = 1'b0;
  always @(negedge clock) begin : monitor
    ev_t      e;
    ev_kind_t k;
    if (!reset_n) begin
      err_q = 1'b0;
    end else begin
      if (move_cmd || done || (error && !err_q)) begin
        k = move_cmd ? EV_MOVE : (done ? EV_DONE : EV_ERR);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
          e.kind = EV_NONE; e.orig = '0; e.fin = '0; e.code = '0;
        end
        check("event_kind", k, e.kind);
        if (k == EV_MOVE) check("ev_move_orig", r_theta_original, e.orig);
        if (k == EV_DONE) begin
          check("ev_done_orig", r_theta_original, e.orig);
          check("ev_done_final", r_theta_final, e.fin);
        end
        if (k == EV_ERR) check("ev_err_code", error_code, e.code);
      end
      err_q = error;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget (%0d/%0d checks passed so far)",
             n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state, observed asynchronously before any clock edge is seen
    #2 reset_n = 1'b0;
    #1 check("reset_outputs",
             {busy, done, move_cmd, error, error_code, r_theta_original, r_theta_final}, '0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick(2);

    // 1: nominal sequence
    pulse_start();
    check("t1_busy", busy, 1);
    send(2, 100);
    check("t1_no_early_move", move_cmd, 0);
    push_ev(EV_MOVE, 12'h265, '0, '0);
    send(2, 102);
    check("t1_move_cmd", move_cmd, 1);
    check("t1_orig", r_theta_original, 12'h265);
    tick(1);
    check("t1_move_once", move_cmd, 0);
    tick(19);
    move_done = 1'b1;
    tick(1);
    move_done = 1'b0;
    check("t1_settle_busy", {busy, error}, 2'b10);
    tick(SETTLE + 2);
    send(3, 80);
    push_ev(EV_DONE, 12'h265, 12'h352, '0);
    send(3, 84);
    check("t1_done", done, 1);
    check("t1_busy_low", busy, 0);
    check("t1_final", r_theta_final, 12'h352);
    tick(1);
    check("t1_done_once", done, 0);
    check("t1_orig_hold", r_theta_original, 12'h265);

    // 2 + 4: disagreeing pair rejected, then move timeout
    pulse_start();
    send(1, 50);
    send(1, 60);
    check("t2_reject", move_cmd, 0);
    push_ev(EV_MOVE, 12'h13C, '0, '0);
    send(1, 61);
    check("t2_move_cmd", move_cmd, 1);
    check("t2_orig", r_theta_original, 12'h13C);
    push_ev(EV_ERR, '0, '0, 2'b10);
    tick(MOVE_TO - 1);
    check("t4_no_early_err", error, 0);
    tick(1);
    check("t4_err", {error, error_code, busy}, {1'b1, 2'b10, 1'b0});
    tick(3);

    // 3: new start clears error; invalid sectors break the pair
    pulse_start();
    check("t3_err_cleared", {error, error_code, busy}, {1'b0, 2'b00, 1'b1});
    send(5, 30);
    send(0, 30);
    send(5, 30);
    send(7, 30);
    send(5, 30);
    check("t3_no_capture", move_cmd, 0);
    push_ev(EV_MOVE, pair(5, 30, 30), '0, '0);
    send(5, 30);
    check("t3_move_cmd", move_cmd, 1);
    check("t3_orig", r_theta_original, pair(5, 30, 30));

    // 5: move_done on the expiry cycle wins; start while busy ignored
    tick(MOVE_TO - 1);
    move_done = 1'b1;
    tick(1);
    move_done = 1'b0;
    check("t5_no_err", {error, busy}, 2'b01);
    pulse_start();
    check("t5_start_ignored", busy, 1);
    tick(SETTLE + 2);
    send(4, 200);
    push_ev(EV_DONE, pair(5, 30, 30), pair(4, 200, 203), '0);
    send(4, 203);
    check("t5_done", done, 1);
    check("t5_final", r_theta_final, pair(4, 200, 203));
    tick(2);

    // Original measurement timeout
    pulse_start();
    tick(MEAS_TO - 1);
    check("t7_no_early_err", error, 0);
    push_ev(EV_ERR, '0, '0, 2'b01);
    tick(1);
    check("t7_err", {error, error_code, busy}, {1'b1, 2'b01, 1'b0});
    tick(2);

    // Final measurement timeout: final word untouched
    pulse_start();
    send(6, 10);
    push_ev(EV_MOVE, pair(6, 10, 12), '0, '0);
    send(6, 12);
    move_done = 1'b1;
    tick(1);
    move_done = 1'b0;
    push_ev(EV_ERR, '0, '0, 2'b11);
    tick(SETTLE + MEAS_TO + 5);
    check("t8_err", {error, error_code}, {1'b1, 2'b11});
    check("t8_final_kept", r_theta_final, pair(4, 200, 203));
    check("t8_orig", r_theta_original, pair(6, 10, 12));

    // 6: reset during SETTLE aborts silently
    pulse_start();
    send(6, 10);
    push_ev(EV_MOVE, pair(6, 10, 10), '0, '0);
    send(6, 10);
    tick(2);
    move_done = 1'b1;
    tick(1);
    move_done = 1'b0;
    tick(3);
    #2 reset_n = 1'b0;
    #1 check("t6_async_clear",
             {busy, done, move_cmd, error, error_code, r_theta_original, r_theta_final}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(40);
    check("t6_idle_after_reset", {busy, error}, 2'b00);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
